// File: rtl/udp_video_pkg.sv
// rtl/udp_video_pkg.sv - scheduler states, header constants and header byte mux; UDP_SCHED_HDR_EN enables the sequence header
`timescale 1ns/1ps
package udp_video_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_GAP  = 3'd4
  } sched_state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

`ifdef UDP_SCHED_HDR_EN
  localparam int HDR_BYTES = 4;
`else
  localparam int HDR_BYTES = 0;
`endif

  localparam int FLAG_FIRST_BIT = 0;
  localparam int FLAG_LAST_BIT  = 1;

  // Header byte at position idx: magic, seq high, seq low, flags.
  function automatic logic [7:0] hdr_byte(input logic [1:0]  idx,
                                          input logic [15:0] seq,
                                          input logic        first,
                                          input logic        last);
    logic [7:0] flags;
    flags = 8'h00;
    flags[FLAG_FIRST_BIT] = first;
    flags[FLAG_LAST_BIT]  = last;
    case (idx)
      2'd0:    hdr_byte = HDR_MAGIC;
      2'd1:    hdr_byte = seq[15:8];
      2'd2:    hdr_byte = seq[7:0];
      default: hdr_byte = flags;
    endcase
  endfunction

endpackage

// File: rtl/udp_video_pkt_sched.sv
// rtl/udp_video_pkt_sched.sv - video FIFO to UDP engine packet scheduler; UDP_SCHED_HDR_EN adds a 4-byte sequence header
`timescale 1ns/1ps
module udp_video_pkt_sched
  import udp_video_pkg::*;
#(
  parameter int PAYLOAD_BYTES  = 1024,
  parameter int PKTS_PER_FRAME = 4050,
  parameter int GAP_CYCLES     = 16
) (
  input  logic        video_rd_clk,
  input  logic        Reset_n,
  input  logic        video_rd_rdy,
  input  logic [7:0]  video_rd_data,
  output logic        video_rd_en,
  output logic        udp_tx_req,
  input  logic        udp_tx_ack,
  output logic [15:0] udp_tx_len,
  input  logic        udp_tx_data_req,
  output logic [7:0]  udp_tx_data,
  output logic        pkt_done,
  output logic        frame_done
);

  localparam int BW = $clog2(PAYLOAD_BYTES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [BW-1:0] PAY_LAST = BW'(PAYLOAD_BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [15:0]   SEQ_LAST = 16'(PKTS_PER_FRAME - 1);

  sched_state_t  state;
  sched_state_t  state_nxt;
  logic [BW-1:0] byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   seq;
  logic [7:0]    hdr_q;
  logic          sel_fifo;
  logic          pay_last;
  logic          gap_last;

  assign udp_tx_len  = 16'(PAYLOAD_BYTES + HDR_BYTES);
  assign pay_last    = (state == ST_PAY) && udp_tx_data_req && (byte_cnt == PAY_LAST);
  assign gap_last    = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  // Bytes leave one cycle after their data_req: header from hdr_q, payload straight from the FIFO.
  assign udp_tx_data = sel_fifo ? video_rd_data : hdr_q;

`ifdef UDP_SCHED_HDR_EN
  localparam logic [1:0] HDR_LAST = 2'(HDR_BYTES - 1);
  logic [1:0] hdr_idx;
  logic       hdr_last;

  assign hdr_last = (state == ST_HDR) && udp_tx_data_req && (hdr_idx == HDR_LAST);

  // Latch the requested header byte and step through the header positions.
  always_ff @(posedge video_rd_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hdr_q   <= 8'h00;
      hdr_idx <= 2'd0;
    end else if ((state == ST_HDR) && udp_tx_data_req) begin
      hdr_q   <= hdr_byte(hdr_idx, seq, seq == 16'd0, seq == SEQ_LAST);
      hdr_idx <= hdr_last ? 2'd0 : hdr_idx + 2'd1;
    end
  end
`else
  assign hdr_q = 8'h00;
`endif

  // State register.
  always_ff @(posedge video_rd_clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode plus the request and FIFO read strobes.
  always_comb begin
    state_nxt   = state;
    udp_tx_req  = 1'b0;
    video_rd_en = 1'b0;
    case (state)
      ST_IDLE: if (video_rd_rdy) state_nxt = ST_REQ;
      ST_REQ: begin
        udp_tx_req = 1'b1;
`ifdef UDP_SCHED_HDR_EN
        if (udp_tx_ack) state_nxt = ST_HDR;
`else
        if (udp_tx_ack) state_nxt = ST_PAY;
`endif
      end
      ST_HDR: begin
`ifdef UDP_SCHED_HDR_EN
        if (hdr_last) state_nxt = ST_PAY;
`else
        state_nxt = ST_PAY;
`endif
      end
      ST_PAY: begin
        video_rd_en = udp_tx_data_req;
        if (pay_last) state_nxt = ST_GAP;
      end
      ST_GAP:  if (gap_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Payload byte count, inter-packet gap count, sequence number and completion pulses.
  always_ff @(posedge video_rd_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      seq        <= 16'd0;
      pkt_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pkt_done   <= pay_last;
      frame_done <= pay_last && (seq == SEQ_LAST);
      if ((state == ST_PAY) && udp_tx_data_req)
        byte_cnt <= pay_last ? '0 : byte_cnt + BW'(1);
      if (state == ST_GAP)
        gap_cnt <= gap_last ? '0 : gap_cnt + GW'(1);
      if (pay_last)
        seq <= (seq == SEQ_LAST) ? 16'd0 : seq + 16'd1;
    end
  end

  // Output select follows the phase of the byte requested in the previous cycle.
  always_ff @(posedge video_rd_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sel_fifo <= 1'b0;
    end else if (udp_tx_data_req) begin
      if (state == ST_HDR)      sel_fifo <= 1'b0;
      else if (state == ST_PAY) sel_fifo <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_video_pkt_sched.sv
// tb/tb_udp_video_pkt_sched.sv - self-checking bench for udp_video_pkt_sched against a byte-stream reference model
`timescale 1ns/1ps
module tb_udp_video_pkt_sched;

  localparam int PAY     = 1024;
  localparam int PKTS    = 3;
  localparam int GAP     = 16;
  localparam int CAP_MAX = 16384;
  localparam int MEM_N   = 8192;
`ifdef UDP_SCHED_HDR_EN
  localparam int HDR_B = 4;
`else
  localparam int HDR_B = 0;
`endif

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        video_rd_rdy;
  logic [7:0]  video_rd_data;
  logic        video_rd_en;
  logic        udp_tx_req;
  logic        udp_tx_ack;
  logic [15:0] udp_tx_len;
  logic        udp_tx_data_req;
  logic [7:0]  udp_tx_data;
  logic        pkt_done;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;
  int tb_cyc   = 0;
  int en_cnt   = 0;
  int en_bad   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int frame_cnt = 0;
  int frame_bad = 0;
  int cap_cnt  = 0;
  int rd_ptr;
  logic req_q = 1'b0;
  logic [7:0] cap_mem  [CAP_MAX];
  logic [7:0] fifo_mem [MEM_N];
  int model_seq;
  int exp_ptr;

  udp_video_pkt_sched #(
    .PAYLOAD_BYTES (PAY),
    .PKTS_PER_FRAME(PKTS),
    .GAP_CYCLES    (GAP)
  ) dut (
    .video_rd_clk   (clk),
    .Reset_n        (Reset_n),
    .video_rd_rdy   (video_rd_rdy),
    .video_rd_data  (video_rd_data),
    .video_rd_en    (video_rd_en),
    .udp_tx_req     (udp_tx_req),
    .udp_tx_ack     (udp_tx_ack),
    .udp_tx_len     (udp_tx_len),
    .udp_tx_data_req(udp_tx_data_req),
    .udp_tx_data    (udp_tx_data),
    .pkt_done       (pkt_done),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc++;

  // FIFO: read data appears one cycle after video_rd_en; its own reset rewinds it.
  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr <= 0;
    end else if (video_rd_en) begin
      video_rd_data <= fifo_mem[rd_ptr % MEM_N];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Monitor: counts strobes/pulses and captures the byte answering each data_req.
  always begin
    @(negedge clk);
    #3;
    if (video_rd_en === 1'b1) en_cnt++;
    if (video_rd_en === 1'b1 && udp_tx_data_req !== 1'b1) en_bad++;
    if (pkt_done === 1'b1) begin
      done_cnt++;
      done_cyc = tb_cyc;
    end
    if (frame_done === 1'b1) begin
      frame_cnt++;
      if (pkt_done !== 1'b1) frame_bad++;
    end
    if (req_q && Reset_n === 1'b1 && cap_cnt < CAP_MAX) begin
      cap_mem[cap_cnt] = udp_tx_data;
      cap_cnt++;
    end
    req_q = (udp_tx_data_req === 1'b1) && (Reset_n === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected i-th byte of a packet with sequence number s whose payload starts at FIFO offset ptr.
  function automatic logic [7:0] exp_byte(input int i, input int s, input int ptr);
    if (i >= HDR_B) return fifo_mem[(ptr + i - HDR_B) % MEM_N];
    case (i)
      0:       return 8'hA5;
      1:       return 8'((s >> 8) & 255);
      2:       return 8'(s & 255);
      default: return 8'(((s == PKTS - 1) ? 2 : 0) + ((s == 0) ? 1 : 0));
    endcase
  endfunction

  // thr: 0 continuous, 1 toggling, 2 random data_req. abort_at >= 0 returns with data_req high
  // just before payload byte abort_at is requested.
  task automatic run_pkt(input int thr, input int ack_dly, input bit chk_gap,
                         input bit drop_rdy, input int abort_at);
    int guard, issued, errs, bad_i, n_tot;
    int base_cap, base_en, base_bad, base_done, base_frame;
    logic r;
    logic [7:0] e, g;
    n_tot = HDR_B + PAY;
    guard = 0;
    while (udp_tx_req !== 1'b1 && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    check("req_rise", udp_tx_req, 1);
    if (chk_gap) check("gap_cycles_done_to_req", tb_cyc - done_cyc, GAP + 1);
    repeat (ack_dly) begin
      @(negedge clk); #1;
    end
    check("req_hold_until_ack", udp_tx_req, 1);
    udp_tx_ack = 1'b1;
    @(negedge clk); #1;
    udp_tx_ack = 1'b0;
    check("req_drop_after_ack", udp_tx_req, 0);
    if (drop_rdy) video_rd_rdy = 1'b0;
    base_cap   = cap_cnt;
    base_en    = en_cnt;
    base_bad   = en_bad;
    base_done  = done_cnt;
    base_frame = frame_cnt;
    issued = 0;
    guard  = 0;
    while ((cap_cnt - base_cap) < n_tot && guard < 20000) begin
      if (abort_at >= 0 && issued == HDR_B + abort_at) return;
      if (issued < n_tot) begin
        case (thr)
          0:       r = 1'b1;
          1:       r = ~guard[0];
          default: r = 1'($urandom_range(0, 1));
        endcase
      end else begin
        r = 1'b0;
      end
      udp_tx_data_req = r;
      if (r) issued++;
      @(negedge clk); #1;
      guard++;
    end
    udp_tx_data_req = 1'b0;
    video_rd_rdy    = 1'b1;
    @(negedge clk); #1;
    errs  = 0;
    bad_i = -1;
    for (int i = 0; i < n_tot; i++) begin
      e = exp_byte(i, model_seq, exp_ptr);
      g = cap_mem[(base_cap + i) % CAP_MAX];
      if (g !== e) begin
        if (bad_i < 0) bad_i = i;
        errs++;
      end
    end
    check($sformatf("pkt_bytes_seq%0d_first_bad_idx%0d", model_seq, bad_i), errs, 0);
`ifdef UDP_SCHED_HDR_EN
    check($sformatf("hdr_flags_seq%0d", model_seq), cap_mem[(base_cap + 3) % CAP_MAX],
          8'(((model_seq == PKTS - 1) ? 2 : 0) + ((model_seq == 0) ? 1 : 0)));
`else
    check("first_byte_is_fifo", cap_mem[base_cap % CAP_MAX], fifo_mem[exp_ptr % MEM_N]);
`endif
    check("rd_en_pulses", en_cnt - base_en, PAY);
    check("rd_en_without_req", en_bad - base_bad, 0);
    check("pkt_done_count", done_cnt - base_done, 1);
    check($sformatf("frame_done_count_seq%0d", model_seq), frame_cnt - base_frame,
          (model_seq == PKTS - 1) ? 1 : 0);
    exp_ptr   = exp_ptr + PAY;
    model_seq = (model_seq + 1) % PKTS;
  endtask

  initial begin
    Reset_n         = 1'b0;
    video_rd_rdy    = 1'b1;
    udp_tx_ack      = 1'b0;
    udp_tx_data_req = 1'b1;
    model_seq       = 0;
    exp_ptr         = 0;
    for (int i = 0; i < MEM_N; i++) fifo_mem[i] = 8'($urandom);
    #3;
    check("rst_tx_req", udp_tx_req, 0);
    check("rst_rd_en", video_rd_en, 0);
    check("rst_tx_data", udp_tx_data, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_frame_done", frame_done, 0);
    check("tx_len", udp_tx_len, PAY + HDR_B);
    repeat (2) @(negedge clk);
    #1;
    video_rd_rdy    = 1'b0;
    udp_tx_data_req = 1'b0;
    Reset_n         = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
    end
    check("idle_without_rdy", udp_tx_req, 0);
    video_rd_rdy = 1'b1;
    @(negedge clk); #1;
    check("rdy_to_req_one_edge", udp_tx_req, 1);

    run_pkt(0, 3, 1'b0, 1'b0, -1);
    run_pkt(1, 1, 1'b1, 1'b0, -1);
    run_pkt(2, int'($urandom_range(0, 4)), 1'b1, 1'b1, -1);
    run_pkt(0, 0, 1'b1, 1'b0, -1);
    run_pkt(0, 2, 1'b1, 1'b0, 500);

    check("pre_reset_rd_en_in_pay", video_rd_en, 1);
    #1 Reset_n = 1'b0;
    #1;
    check("async_rst_tx_req", udp_tx_req, 0);
    check("async_rst_rd_en", video_rd_en, 0);
    check("async_rst_tx_data", udp_tx_data, 0);
    check("async_rst_pkt_done", pkt_done, 0);
    check("async_rst_frame_done", frame_done, 0);
    @(negedge clk); #1;
    udp_tx_data_req = 1'b0;
    model_seq       = 0;
    exp_ptr         = 0;
    @(negedge clk); #1;
    Reset_n = 1'b1;
    run_pkt(1, 1, 1'b0, 1'b0, -1);

    check("frame_done_only_with_pkt_done", frame_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
